// File: rtl/stream_fetch_pkg.sv
// Shared types and default sizing for the stream_fetch read sequencer.
package stream_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam int DEF_ADDR_W  = 13;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_TIMEOUT = 31;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage is cleared on reset so the head word reads 0 when empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/stream_fetch.sv
// Walks a contiguous word range, one outstanding controller request at a time,
// and streams the returned words out through a small FIFO.
module stream_fetch
   import stream_fetch_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              mem_go,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e                     state_q, state_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic [ADDR_W-1:0]          remaining_q, remaining_d;
   logic [TW-1:0]              tmo_q, tmo_d;
   logic                       err_q, err_d;
   logic                       done_q, done_d;
   logic                       mem_go_q, mem_go_d;
   logic                       busy_q, busy_d;
   logic                       fifo_push, fifo_empty, fifo_full;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      done_d      = 1'b0;
      mem_go_d    = 1'b0;
      fifo_push   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  addr_d      = base_addr;
                  remaining_d = word_count;
                  err_d       = 1'b0;
                  tmo_d       = '0;
                  state_d     = ISSUE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            // Only request when the returned word is guaranteed a FIFO slot.
            if (!fifo_full) begin
               mem_go_d = 1'b1;
               tmo_d    = '0;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (mem_valid) begin
               fifo_push   = 1'b1;
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - ADDR_W'(1);
               state_d     = (remaining_q == ADDR_W'(1)) ? DRAIN : ISSUE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DRAIN: begin
            if (fifo_count == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         mem_go_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         done_q      <= done_d;
         mem_go_q    <= mem_go_d;
         busy_q      <= busy_d;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (mem_data),
      .pop       (out_ready),
      .rd_data   (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign mem_go    = mem_go_q;
   assign mem_addr  = addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_stream_fetch.sv
// Directed bench for stream_fetch: 10-cycle controller model, output and
// address scoreboards, and a final one-line report.
module tb_stream_fetch;
   import stream_fetch_pkg::*;

   localparam int AW    = 13;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int TMO   = 31;
   localparam int LAT   = 10;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] word_count;
   logic          mem_go;
   logic [AW-1:0] mem_addr;
   logic          mem_valid;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic          err;

   stream_fetch #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_go     (mem_go),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int            checks  = 0;
   int            errors  = 0;
   int            go_cnt  = 0;
   int            done_cnt = 0;
   bit            ctrl_en = 1'b1;
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] addr_exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_word(input logic [AW-1:0] a);
      return 64'hC0DE_0000_0000_0000 | {{(DW-AW){1'b0}}, a};
   endfunction

   // ---------------- controller model ----------------
   initial begin
      mem_valid = 1'b0;
      mem_data  = '0;
      forever begin
         @(negedge clk);
         mem_valid = 1'b0;
         mem_data  = {$urandom, $urandom};
         if (rst && mem_go && ctrl_en) begin
            repeat (LAT - 1) @(negedge clk);
            mem_valid = 1'b1;
            mem_data  = mk_word(mem_addr);
         end
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_word: got unexpected %0h, expected no word", out_data);
            end else begin
               check("out_word", out_data, exp_q.pop_front());
            end
         end
         if (mem_go) begin
            go_cnt++;
            if (addr_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mem_addr: got unexpected request %0h, expected none", mem_addr);
            end else begin
               check("mem_addr", mem_addr, addr_exp_q.pop_front());
            end
         end
         if (done) done_cnt++;
      end
   end

   always @(posedge clk) begin
      if (rst && dut.fifo_push) begin
         checks++;
         if (dut.u_fifo.full) begin
            errors++;
            $display("FAIL push_into_full: got full=1 on push, expected full=0");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic expect_range(input logic [AW-1:0] base, input int n, input bit with_data);
      logic [AW-1:0] a;
      a = base;
      for (int i = 0; i < n; i++) begin
         addr_exp_q.push_back(a);
         if (with_data) exp_q.push_back(mk_word(a));
         a = a + AW'(1);
      end
   endtask

   task automatic start_xfer(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
      @(negedge clk);
      start      = 1'b1;
      base_addr  = base;
      word_count = cnt;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      int n;
      n = 0;
      while (!done && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_seen"}, done, 1'b1);
      @(negedge clk);
      check({name, "_done_one_cycle"}, done, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0;
      int g0;
      int n;
      rst        = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      out_ready  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_go", mem_go, 1'b0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      rst = 1'b1;

      // Three words, downstream always ready.
      expect_range(13'h010, 3, 1'b1);
      d0 = done_cnt;
      start_xfer(13'h010, 13'd3);
      check("t1_busy_after_start", busy, 1'b1);
      @(negedge clk);
      check("t1_mem_go_first", mem_go, 1'b1);
      wait_done(300, "t1");
      check("t1_done_count", done_cnt - d0, 1);
      check("t1_err", err, 1'b0);
      check("t1_busy_idle", busy, 1'b0);
      check("t1_words_left", exp_q.size(), 0);
      check("t1_addrs_left", addr_exp_q.size(), 0);

      // Backpressure: six words into a four-entry FIFO.
      out_ready = 1'b0;
      expect_range(13'h100, 6, 1'b1);
      g0 = go_cnt;
      start_xfer(13'h100, 13'd6);
      repeat (150) @(negedge clk);
      check("t2_go_while_stalled", go_cnt - g0, 4);
      check("t2_state_issue", 64'(dut.state_q), 64'(ISSUE));
      check("t2_no_go_stalled", mem_go, 1'b0);
      check("t2_out_valid_stalled", out_valid, 1'b1);
      out_ready = 1'b1;
      wait_done(400, "t2");
      check("t2_go_total", go_cnt - g0, 6);
      check("t2_words_left", exp_q.size(), 0);

      // Address wrap.
      expect_range(13'h1FFF, 2, 1'b1);
      start_xfer(13'h1FFF, 13'd2);
      wait_done(200, "t3");
      check("t3_addrs_left", addr_exp_q.size(), 0);
      check("t3_words_left", exp_q.size(), 0);

      // Controller never answers.
      ctrl_en = 1'b0;
      expect_range(13'h020, 1, 1'b0);
      start_xfer(13'h020, 13'd5);
      @(negedge clk);
      check("t4_go", mem_go, 1'b1);
      n = 0;
      while (!err && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_timeout_cycles", n, TMO);
      wait_done(5, "t4");
      check("t4_err_sticky", err, 1'b1);
      check("t4_no_words", out_valid, 1'b0);
      ctrl_en = 1'b1;
      expect_range(13'h030, 1, 1'b1);
      start_xfer(13'h030, 13'd1);
      check("t4_err_cleared", err, 1'b0);
      wait_done(100, "t4b");
      check("t4b_err", err, 1'b0);

      // Zero-length transfer.
      g0 = go_cnt;
      @(negedge clk);
      start      = 1'b1;
      base_addr  = 13'h050;
      word_count = '0;
      @(negedge clk);
      start = 1'b0;
      check("t5_done", done, 1'b1);
      check("t5_busy", busy, 1'b0);
      @(negedge clk);
      check("t5_done_one_cycle", done, 1'b0);
      repeat (5) @(negedge clk);
      check("t5_no_go", go_cnt - g0, 0);

      // Reset in the middle of WAIT, controller answers afterwards.
      expect_range(13'h040, 1, 1'b0);
      start_xfer(13'h040, 13'd2);
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_mem_go", mem_go, 1'b0);
      check("t6_rst_mem_addr", mem_addr, 0);
      check("t6_rst_out_valid", out_valid, 1'b0);
      check("t6_rst_out_data", out_data, 0);
      check("t6_rst_done", done, 1'b0);
      check("t6_rst_err", err, 1'b0);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      check("t6_late_out_valid", out_valid, 1'b0);
      check("t6_late_busy", busy, 1'b0);
      check("t6_late_mem_addr", mem_addr, 0);
      check("t6_late_done", done, 1'b0);
      check("final_words_left", exp_q.size(), 0);
      check("final_addrs_left", addr_exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
